// File: rtl/seq_det_prog.sv
// -----------------------------------------------------------------------------
// seq_det_prog -- programmable serial pattern detector
//
// Compares a qualified serial bit stream against a runtime-loaded pattern of
// 1..MAX_LEN bits. Detection can be overlapping or non-overlapping. Each hit
// produces a registered one-cycle match pulse and bumps a saturating counter.
// The reset configuration behaves as a fixed "1011" overlapping detector.
//
// Optional feature (macro SEQDET_GAP_TIMEOUT_EN):
//   When defined, a run of GAP_MAX consecutive cycles without din_valid clears
//   the bit history, so a pattern split across a long idle gap does not match.
//   When undefined, idle gaps never disturb the history.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   cfg_we       in   load cfg_pattern / cfg_len / cfg_overlap this cycle
//   cfg_pattern  in   pattern, bit cfg_len-1 earliest in time, bit 0 latest
//   cfg_len      in   pattern length (1..MAX_LEN accepted)
//   cfg_overlap  in   1 = overlapping detection, 0 = non-overlapping
//   din_valid    in   din is qualified this cycle
//   din          in   serial data bit
//   clr_count    in   synchronous clear of match_count (wins over a hit)
//   match        out  one-cycle registered match pulse
//   match_count  out  saturating match counter
//   cfg_err      out  one-cycle pulse after a rejected configuration write
// -----------------------------------------------------------------------------
module seq_det_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1011,
  parameter logic [LEN_W-1:0]   RST_LEN     = 4'd4,
  parameter logic               RST_OVERLAP = 1'b1
`ifdef SEQDET_GAP_TIMEOUT_EN
  ,
  parameter int                 GAP_MAX     = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  input  logic               clr_count,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] mask_s;
  logic [MAX_LEN-1:0] hist_sh_s;
  logic [LEN_W-1:0]   fill_inc_s;
  logic               cfg_ok_s;
  logic               hit_s;

`ifdef SEQDET_GAP_TIMEOUT_EN
  localparam int               GAP_W     = $clog2(GAP_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_MAX_L = GAP_W'(GAP_MAX);
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  // Hit detection: only the low len bits of history and pattern are compared.
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (i < int'(len_q));
    end
    hist_sh_s  = {hist_q[MAX_LEN-2:0], din};
    // Saturating fill written as a compare so fill+1 can never wrap.
    fill_inc_s = (fill_q >= len_q) ? len_q : (fill_q + {{(LEN_W-1){1'b0}}, 1'b1});
    cfg_ok_s   = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= MAX_LEN_L);
    hit_s      = din_valid && !cfg_we && (fill_inc_s == len_q) &&
                 (((hist_sh_s ^ pat_q) & mask_s) == {MAX_LEN{1'b0}});
  end

  // Next-state logic for configuration, history, fill, outputs and counter.
  always_comb begin
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;
    cnt_d     = cnt_q;
`ifdef SEQDET_GAP_TIMEOUT_EN
    gap_d     = gap_q;
`endif

    if (cfg_we) begin
      // Config has priority; any din bit this cycle is dropped.
`ifdef SEQDET_GAP_TIMEOUT_EN
      gap_d = {GAP_W{1'b0}};
`endif
      if (cfg_ok_s) begin
        pat_d  = cfg_pattern;
        len_d  = cfg_len;
        ovl_d  = cfg_overlap;
        hist_d = {MAX_LEN{1'b0}};
        fill_d = {LEN_W{1'b0}};
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (din_valid) begin
      hist_d = hist_sh_s;
`ifdef SEQDET_GAP_TIMEOUT_EN
      gap_d  = {GAP_W{1'b0}};
`endif
      if (hit_s) begin
        match_d = 1'b1;
        // Non-overlap restarts the fill so the next match needs len fresh bits.
        fill_d  = ovl_q ? fill_inc_s : {LEN_W{1'b0}};
      end else begin
        fill_d  = fill_inc_s;
      end
    end else begin
`ifdef SEQDET_GAP_TIMEOUT_EN
      // Count idle cycles; clear history once when the limit is reached.
      if (gap_q != GAP_MAX_L) begin
        gap_d = gap_q + {{(GAP_W-1){1'b0}}, 1'b1};
        if (gap_d == GAP_MAX_L) begin
          hist_d = {MAX_LEN{1'b0}};
          fill_d = {LEN_W{1'b0}};
        end else begin
          hist_d = hist_q;
        end
      end else begin
        gap_d = gap_q;
      end
`else
      hist_d = hist_q;
`endif
    end

    if (clr_count) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (hit_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous reset to the default 1011 configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q     <= RST_PATTERN;
      len_q     <= RST_LEN;
      ovl_q     <= RST_OVERLAP;
      hist_q    <= {MAX_LEN{1'b0}};
      fill_q    <= {LEN_W{1'b0}};
      match_q   <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      cfg_err_q <= 1'b0;
`ifdef SEQDET_GAP_TIMEOUT_EN
      gap_q     <= {GAP_W{1'b0}};
`endif
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
`ifdef SEQDET_GAP_TIMEOUT_EN
      gap_q     <= gap_d;
`endif
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// -----------------------------------------------------------------------------
// Directed testbench for seq_det_prog. Two instances share the stimulus: the
// default build and one with a 2-bit counter for the saturation checks.
// -----------------------------------------------------------------------------
module tb_seq_det_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       din_valid;
  logic       din;
  logic       clr_count;
  logic       match, cfg_err;
  logic [7:0] match_count;
  logic       match2, cfg_err2;
  logic [1:0] match_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_det_prog dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid),
    .din(din), .clr_count(clr_count), .match(match),
    .match_count(match_count), .cfg_err(cfg_err)
  );

  seq_det_prog #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid),
    .din(din), .clr_count(clr_count), .match(match2),
    .match_count(match_count2), .cfg_err(cfg_err2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One valid bit; check match and count of the default instance afterwards.
  task automatic send(input logic b, input logic em, input logic [7:0] ec);
    cfg_we    = 1'b0;
    din_valid = 1'b1;
    din       = b;
    @(posedge clk); #1;
    din_valid = 1'b0;
    check_val("match", match, em);
    check_val("count", match_count, ec);
  endtask

  task automatic idle();
    din_valid = 1'b0;
    @(posedge clk); #1;
    check_val("idle_match", match, 1'b0);
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    din_valid   = 1'b0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check_val("cfg_ok_err", cfg_err, 1'b0);
    check_val("cfg_match", match, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0;
    cfg_overlap = 1'b0; din_valid = 1'b0; din = 1'b0; clr_count = 1'b0;
    #12;
    check_val("rst_match", match, 1'b0);
    check_val("rst_count", match_count, 8'd0);
    check_val("rst_cfg_err", cfg_err, 1'b0);
    check_val("rst_count2", match_count2, 2'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset config: 1011 overlapping on 1011011.
    send(1'b1, 1'b0, 8'd0); send(1'b0, 1'b0, 8'd0); send(1'b1, 1'b0, 8'd0);
    send(1'b1, 1'b1, 8'd1); send(1'b0, 1'b0, 8'd1); send(1'b1, 1'b0, 8'd1);
    send(1'b1, 1'b1, 8'd2);

    // Non-overlapping 1011 on the same stream; config leaves the count alone.
    load_cfg(8'h0B, 4'd4, 1'b0);
    check_val("cnt_after_cfg", match_count, 8'd2);
    send(1'b1, 1'b0, 8'd2); send(1'b0, 1'b0, 8'd2); send(1'b1, 1'b0, 8'd2);
    send(1'b1, 1'b1, 8'd3); send(1'b0, 1'b0, 8'd3); send(1'b1, 1'b0, 8'd3);
    send(1'b1, 1'b0, 8'd3);

    // 8-bit pattern 11100101 with three idle cycles after bit 3.
    load_cfg(8'hE5, 4'd8, 1'b1);
    send(1'b1, 1'b0, 8'd3); send(1'b1, 1'b0, 8'd3); send(1'b1, 1'b0, 8'd3);
    idle(); idle(); idle();
    send(1'b0, 1'b0, 8'd3); send(1'b0, 1'b0, 8'd3); send(1'b1, 1'b0, 8'd3);
    send(1'b0, 1'b0, 8'd3); send(1'b1, 1'b1, 8'd4);

    // Rejected writes mid-pattern keep config and history; their din is dropped.
    load_cfg(8'h0B, 4'd4, 1'b1);
    send(1'b1, 1'b0, 8'd4); send(1'b0, 1'b0, 8'd4);
    cfg_we = 1'b1; cfg_pattern = 8'hFF; cfg_len = 4'd0; cfg_overlap = 1'b0;
    din_valid = 1'b1; din = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; din_valid = 1'b0;
    check_val("err_len0", cfg_err, 1'b1);
    check_val("err_len0_match", match, 1'b0);
    @(posedge clk); #1;
    check_val("err_len0_pulse", cfg_err, 1'b0);
    cfg_we = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd9;
    din_valid = 1'b1; din = 1'b0;
    @(posedge clk); #1;
    cfg_we = 1'b0; din_valid = 1'b0;
    check_val("err_len9", cfg_err, 1'b1);
    @(posedge clk); #1;
    check_val("err_len9_pulse", cfg_err, 1'b0);
    send(1'b1, 1'b0, 8'd4); send(1'b1, 1'b1, 8'd5);

    // Clear both counters, then len=1 saturation on the 2-bit counter.
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    check_val("clr_count", match_count, 8'd0);
    check_val("clr_count2", match_count2, 2'd0);
    load_cfg(8'h01, 4'd1, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      send(1'b1, 1'b1, 8'(i));
      check_val("sat_count2", match_count2, (i > 3) ? 2'd3 : 2'(i));
    end
    clr_count = 1'b1;
    send(1'b1, 1'b1, 8'd0);
    clr_count = 1'b0;
    check_val("clr_win_count2", match_count2, 2'd0);

    // len=1 non-overlapping still hits on every matching bit.
    load_cfg(8'h01, 4'd1, 1'b0);
    send(1'b1, 1'b1, 8'd1); send(1'b0, 1'b0, 8'd1); send(1'b1, 1'b1, 8'd2);

    // Asynchronous reset mid-cycle: outputs clear before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_val("arst_match", match, 1'b0);
    check_val("arst_count", match_count, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    // Config is back to 1011 length 4, so a single 1 is not a hit.
    send(1'b1, 1'b0, 8'd0);
    send(1'b1, 1'b0, 8'd0); send(1'b0, 1'b0, 8'd0); send(1'b1, 1'b0, 8'd0);
    send(1'b1, 1'b1, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
